// File: rtl/shift_reg_pkg.sv
// Shared op-code and FSM state encodings for the universal shift register.
package shift_reg_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-step next-value function of the shift register, shared by the
// single-step and sequenced paths.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] next_q
);

    // Select the post-step register value; reserved code 111 holds.
    always_comb begin
        next_q = q;
        case (op)
            OP_HOLD: next_q = q;
            OP_SHR:  next_q = {sin_msb, q[WIDTH-1:1]};
            OP_SHL:  next_q = {q[WIDTH-2:0], sin_lsb};
            OP_LOAD: next_q = d;
            OP_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            OP_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/shift_register_seq.sv
// WIDTH-bit universal shift register with single-step enable and a
// sequenced N-step operation under a busy/done handshake.
module shift_register_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             op_start,
    input  logic [2:0]       op_mode,
    input  logic [CNT_W-1:0] op_count,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       op_mode_r;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       step_op_s;
    logic [WIDTH-1:0] step_q_s;

    // While running, the latched op code drives the step; otherwise the live mode.
    always_comb begin
        step_op_s = mode;
        if (state_r == ST_RUN) begin
            step_op_s = op_mode_r;
        end else begin
            step_op_s = mode;
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_r),
        .op      (step_op_s),
        .d       (d),
        .sin_msb (sin_msb),
        .sin_lsb (sin_lsb),
        .next_q  (step_q_s)
    );

    // Register, FSM and step counter; a start edge never applies a step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            op_mode_r <= OP_HOLD;
            q_r       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_start && (op_count == '0)) begin
                        done_r <= 1'b1;
                    end else if (op_start) begin
                        op_mode_r <= op_mode;
                        cnt_r     <= op_count;
                        state_r   <= ST_RUN;
                        busy_r    <= 1'b1;
                    end else if (en) begin
                        q_r <= step_q_s;
                    end else begin
                        q_r <= q_r;
                    end
                end
                ST_RUN: begin
                    q_r   <= step_q_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign q        = q_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sout_msb = q_r[WIDTH-1];
    assign sout_lsb = q_r[0];

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed scoreboard bench for shift_register_seq at WIDTH=8.
module tb_shift_register_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_msb;
    logic             sin_lsb;
    logic             op_start;
    logic [2:0]       op_mode;
    logic [CNT_W-1:0] op_count;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    shift_register_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .op_start (op_start),
        .op_mode  (op_mode),
        .op_count (op_count),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        exp_t e;
        e.tag  = tag;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop and compare the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".q"}, q, e.q);
            chk({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
            chk({e.tag, ".done"}, {7'd0, done}, {7'd0, e.done});
            chk({e.tag, ".sout_msb"}, {7'd0, sout_msb}, {7'd0, e.q[7]});
            chk({e.tag, ".sout_lsb"}, {7'd0, sout_lsb}, {7'd0, e.q[0]});
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00;
        sin_msb = 1'b0; sin_lsb = 1'b0;
        op_start = 1'b0; op_mode = 3'b000; op_count = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset.q", q, 8'h00);
        chk("reset.busy", {7'd0, busy}, 8'h00);
        chk("reset.done", {7'd0, done}, 8'h00);
        reset = 1'b0;

        // Single steps
        en = 1'b1; mode = 3'b011; d = 8'hA5; push("load", 8'hA5, 1'b0, 1'b0); tick();
        mode = 3'b110; push("asr", 8'hD2, 1'b0, 1'b0); tick();
        mode = 3'b101; push("rol", 8'hA5, 1'b0, 1'b0); tick();
        mode = 3'b001; sin_msb = 1'b0; push("shr", 8'h52, 1'b0, 1'b0); tick();
        mode = 3'b010; sin_lsb = 1'b1; push("shl", 8'hA5, 1'b0, 1'b0); tick();
        en = 1'b0; push("idle_hold", 8'hA5, 1'b0, 1'b0); tick();

        // Sequenced rotate right by 3
        en = 1'b1; mode = 3'b011; d = 8'h81; push("load81", 8'h81, 1'b0, 1'b0); tick();
        en = 1'b0; op_start = 1'b1; op_mode = 3'b100; op_count = 4'd3;
        push("ror3.start", 8'h81, 1'b1, 1'b0); tick();
        op_start = 1'b0;
        push("ror3.s1", 8'hC0, 1'b1, 1'b0); tick();
        push("ror3.s2", 8'h60, 1'b1, 1'b0); tick();
        push("ror3.s3", 8'h30, 1'b0, 1'b1); tick();
        push("ror3.after", 8'h30, 1'b0, 1'b0); tick();

        // Inputs ignored while busy
        op_start = 1'b1; op_mode = 3'b001; op_count = 4'd2; sin_msb = 1'b0;
        push("ign.start", 8'h30, 1'b1, 1'b0); tick();
        en = 1'b1; mode = 3'b011; d = 8'hFF; op_count = 4'd5;
        push("ign.s1", 8'h18, 1'b1, 1'b0); tick();
        push("ign.s2", 8'h0C, 1'b0, 1'b1); tick();
        op_start = 1'b0; en = 1'b0;
        push("ign.after1", 8'h0C, 1'b0, 1'b0); tick();
        push("ign.after2", 8'h0C, 1'b0, 1'b0); tick();

        // Zero count
        op_start = 1'b1; op_mode = 3'b101; op_count = 4'd0;
        push("zero.done", 8'h0C, 1'b0, 1'b1); tick();
        op_start = 1'b0;
        push("zero.after", 8'h0C, 1'b0, 1'b0); tick();

        // Start beats en; then restart in the done cycle
        op_start = 1'b1; op_mode = 3'b010; op_count = 4'd1; sin_lsb = 1'b0;
        en = 1'b1; mode = 3'b011; d = 8'hFF;
        push("prio.start", 8'h0C, 1'b1, 1'b0); tick();
        op_start = 1'b0; en = 1'b0;
        push("prio.s1", 8'h18, 1'b0, 1'b1); tick();
        op_start = 1'b1; op_mode = 3'b100; op_count = 4'd2;
        push("restart.start", 8'h18, 1'b1, 1'b0); tick();
        op_start = 1'b0;
        push("restart.s1", 8'h0C, 1'b1, 1'b0); tick();
        push("restart.s2", 8'h06, 1'b0, 1'b1); tick();

        // Full shift-out with count = WIDTH
        en = 1'b1; mode = 3'b011; d = 8'hFF; push("loadFF", 8'hFF, 1'b0, 1'b0); tick();
        en = 1'b0; op_start = 1'b1; op_mode = 3'b010; op_count = 4'd8; sin_lsb = 1'b0;
        push("shl8.start", 8'hFF, 1'b1, 1'b0); tick();
        op_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push($sformatf("shl8.s%0d", i), 8'(8'hFF << i), (i < 8), (i == 8));
            tick();
        end

        // Reset in the middle of a run
        en = 1'b1; mode = 3'b011; d = 8'h81; push("rst.load", 8'h81, 1'b0, 1'b0); tick();
        en = 1'b0; op_start = 1'b1; op_mode = 3'b100; op_count = 4'd4;
        push("rst.start", 8'h81, 1'b1, 1'b0); tick();
        op_start = 1'b0;
        push("rst.s1", 8'hC0, 1'b1, 1'b0); tick();
        reset = 1'b1;
        #1;
        chk("midrst.q", q, 8'h00);
        chk("midrst.busy", {7'd0, busy}, 8'h00);
        chk("midrst.done", {7'd0, done}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("postrst%0d", i), 8'h00, 1'b0, 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
